// File: rtl/bf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf_pkg : shared opcodes, UART FSM states and frame length.       |
// | Config macro: BF_UART_PARITY_EN (adds even-parity bit, 8E1).     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bf_pkg;

    localparam logic [2:0] OP_INC   = 3'b111;
    localparam logic [2:0] OP_DEC   = 3'b110;
    localparam logic [2:0] OP_RIGHT = 3'b101;
    localparam logic [2:0] OP_LEFT  = 3'b100;
    localparam logic [2:0] OP_OUT   = 3'b011;
    localparam logic [2:0] OP_JZ    = 3'b010;
    localparam logic [2:0] OP_JNZ   = 3'b001;
    localparam logic [2:0] OP_NOP   = 3'b000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

`ifdef BF_UART_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bf_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf_sync_fifo : single-clock FIFO with occupancy count.           |
// | Caller qualifies push/pop against full/empty.  Rev 1.0           |
// +------------------------------------------------------------------+
module bf_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;

    // Pointers wrap naturally; the extra level bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_level == C_DEPTH);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/bf_uart_out.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bf_uart_out : buffers core output bytes and sends them as UART.  |
// | Config macro: BF_UART_PARITY_EN (8E1 instead of 8N1). Rev 1.0    |
// +------------------------------------------------------------------+
module bf_uart_out
    import bf_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int STALL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cout,
    input  logic [DATA_W-1:0]             out_data,
    output logic                          stall,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] C_STALL_LVL = LVL_W'(FIFO_DEPTH - STALL_MARGIN);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_stall;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_term;
    logic              w_tx_next;
    logic [DATA_W-1:0] w_head;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W-1:0]  w_level_next;

    bf_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (out_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_term       = (r_cnt == C_CNT_LAST);
    // A full FIFO still accepts a byte on the edge that frees a slot.
    assign w_push       = cout & (~w_full | w_pop);
    assign w_level_next = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_term) w_state_next = DATA;
            end
            DATA: begin
                if (w_term && (r_bit == 3'd7)) begin
`ifdef BF_UART_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_term) w_state_next = STOP;
            end
            STOP: begin
                if (w_term) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level for the current state; registered below so the pin never glitches.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_shift[r_bit];
            PARITY:  w_tx_next = even_parity(r_shift[7:0]);
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_stall <= (w_level_next >= C_STALL_LVL);
            if (cout && !w_push) r_overflow <= 1'b1;
            if (w_pop) r_shift <= w_head;
            if ((r_state == IDLE) || w_term) r_cnt <= '0;
            else                             r_cnt <= r_cnt + 1'b1;
            if ((r_state == DATA) && w_term) r_bit <= r_bit + 1'b1;
        end
    end

    assign stall      = r_stall;
    assign uart_tx    = r_tx;
    assign busy       = (r_state != IDLE) | ~w_empty;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
